// File: rtl/iv_press_checker.sv
// iv_press_checker
//   Checks a player's button presses against an externally stored color
//   sequence. Raw buttons are synchronized and debounced, then an FSM walks
//   the sequence one step per press/release, reporting each correct press and
//   a final pass or fail.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles the synchronized vector must be stable (>= 2)
//   TIMEOUT_CYCLES   max cycles in WAIT_PRESS before a timeout fail
//
// Build option
//   IV_PRESS_TIMEOUT_EN  when defined, builds the WAIT_PRESS timeout counter;
//                        otherwise WAIT_PRESS waits indefinitely.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   btn[3:0]     raw asynchronous buttons, bit i = color i
//   start        one-cycle pulse starting a round (ignored while busy)
//   len[5:0]     round length 0..32, latched on accepted start
//   exp_idx[4:0] sequence-memory address of the expected step
//   exp_color    expected color at exp_idx (combinational read)
//   busy         high in every state except IDLE
//   press_valid  one-cycle pulse per correct press
//   press_color  color of the last accepted press, held
//   pass / fail  one-cycle round result pulses
//   fail_code    00 none, 01 wrong color, 10 multiple buttons, 11 timeout

module iv_press_checker #(
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter int unsigned TIMEOUT_CYCLES  = 1 << 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       start,
    input  logic [5:0] len,
    output logic [4:0] exp_idx,
    input  logic [1:0] exp_color,
    output logic       busy,
    output logic       press_valid,
    output logic [1:0] press_color,
    output logic       pass,
    output logic       fail,
    output logic [1:0] fail_code
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        DONE
    } state_t;

    localparam int unsigned      DEB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchronizer and shared debounce counter
    // ------------------------------------------------------------------
    logic [3:0]       sync_1;
    logic [3:0]       sync_2;
    logic [3:0]       sync_q;
    logic [3:0]       deb;
    logic [DEB_W-1:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= '0;
            sync_2  <= '0;
            sync_q  <= '0;
            deb     <= '0;
            deb_cnt <= '0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            sync_q <= sync_2;
            if (sync_2 == deb) begin
                deb_cnt <= '0;
            end else if (sync_2 != sync_q) begin
                // A fresh change counts as the first stable cycle, so the
                // restart value is 1; a change straight out of a stable deb
                // therefore behaves exactly like incrementing from 0.
                deb_cnt <= DEB_W'(1);
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= sync_2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    state_t     state, state_d;
    logic [4:0] idx, idx_d;
    logic [5:0] len_q, len_d;
    logic [1:0] code_d;
    logic [1:0] color_d;
    logic       pv_d, pass_d, fail_d;
    logic       armed, armed_d;
    logic       timeout_hit;

    // ------------------------------------------------------------------
    // Optional WAIT_PRESS timeout; the counter is held at zero outside
    // WAIT_PRESS, so it is already clear on every entry.
    // ------------------------------------------------------------------
`ifdef IV_PRESS_TIMEOUT_EN
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != WAIT_PRESS) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == WAIT_PRESS) && (to_cnt == TO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    logic       one_hot;
    logic [1:0] deb_color;
    logic       press;

    always_comb begin
        deb_color = 2'd0;
        case (deb)
            4'b0001: deb_color = 2'd0;
            4'b0010: deb_color = 2'd1;
            4'b0100: deb_color = 2'd2;
            4'b1000: deb_color = 2'd3;
            default: deb_color = 2'd0;
        endcase
    end

    assign one_hot = (deb inside {4'b0001, 4'b0010, 4'b0100, 4'b1000});
    // armed means deb has been 0000 since entering WAIT_PRESS, so a button
    // still held on entry is not mistaken for a new press.
    assign press   = (deb != 4'b0000) && armed;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        len_d   = len_q;
        code_d  = fail_code;
        color_d = press_color;
        armed_d = armed;
        pv_d    = 1'b0;
        pass_d  = 1'b0;
        fail_d  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    len_d  = len;
                    idx_d  = '0;
                    code_d = 2'b00;
                    if (len == 6'd0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = WAIT_PRESS;
                        armed_d = (deb == 4'b0000);
                    end
                end
            end

            WAIT_PRESS: begin
                if (press) begin
                    if (!one_hot) begin
                        state_d = DONE;
                        fail_d  = 1'b1;
                        code_d  = 2'b10;
                    end else if (deb_color != exp_color) begin
                        state_d = DONE;
                        fail_d  = 1'b1;
                        code_d  = 2'b01;
                    end else begin
                        state_d = WAIT_RELEASE;
                        pv_d    = 1'b1;
                        color_d = deb_color;
                    end
                end else if (timeout_hit) begin
                    state_d = DONE;
                    fail_d  = 1'b1;
                    code_d  = 2'b11;
                end else if (deb == 4'b0000) begin
                    armed_d = 1'b1;
                end
            end

            WAIT_RELEASE: begin
                if (deb == 4'b0000) begin
                    if (({1'b0, idx} + 6'd1) == len_q) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        idx_d   = idx + 5'd1;
                        state_d = WAIT_PRESS;
                        armed_d = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            len_q       <= '0;
            fail_code   <= '0;
            press_color <= '0;
            press_valid <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            len_q       <= len_d;
            fail_code   <= code_d;
            press_color <= color_d;
            press_valid <= pv_d;
            pass        <= pass_d;
            fail        <= fail_d;
            armed       <= armed_d;
        end
    end

    assign exp_idx = idx;
    assign busy    = (state != IDLE);

endmodule

// File: doc/iv_press_checker.md
IV_PRESS_CHECKER -- requirements
Module: iv_press_checker

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1024: cycles the synchronized button vector must stay stable before it is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 2^20: maximum cycles allowed between entering WAIT_PRESS and a press.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port btn, input, 4: raw asynchronous buttons; bit i is color i.
REQ-006 Port start, input, 1: one-cycle pulse that begins checking a round.
REQ-007 Port len, input, 6: round length 0..32, sampled when start is accepted.
REQ-008 Port exp_idx, output, 5: sequence-memory address of the expected step.
REQ-009 Port exp_color, input, 2: expected color at exp_idx; combinational read, valid in the same cycle.
REQ-010 Port busy, output, 1: high in every state other than IDLE.
REQ-011 Port press_valid, output, 1: one-cycle pulse for each correct press.
REQ-012 Port press_color, output, 2: color of the last accepted press; held between presses.
REQ-013 Port pass, output, 1: one-cycle pulse when the round is completed.
REQ-014 Port fail, output, 1: one-cycle pulse when the round is failed.
REQ-015 Port fail_code, output, 2: fail reason (00 none, 01 wrong color, 10 multiple buttons, 11 timeout); held until the next accepted start.

Function
REQ-016 btn SHALL pass through a 2-flop synchronizer into a shared debounce counter.
REQ-017 Debounce: when sync != deb the counter increments, and deb <= sync on the cycle the counter reaches DEBOUNCE_CYCLES-1; when sync == deb the counter clears. Any bit change restarts the count.
REQ-018 The state machine SHALL have the states IDLE, WAIT_PRESS, WAIT_RELEASE and DONE.
REQ-019 IDLE: start=1 latches len and clears idx and fail_code.
  - len=0: go to DONE with a pass.
  - otherwise: go to WAIT_PRESS.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 exp_idx SHALL equal idx at all times.
REQ-022 A press is deb changing from 0000 to nonzero while in WAIT_PRESS; nonzero deb on entry to WAIT_PRESS is not a press until deb returns to 0000.
REQ-023 Press with deb one-hot and color == exp_color:
  - next cycle, press_valid=1 and press_color=color;
  - state goes to WAIT_RELEASE.
REQ-024 Press with deb one-hot and color != exp_color: go to DONE with fail_code=01.
REQ-025 Press with deb not one-hot: go to DONE with fail_code=10.
REQ-026 WAIT_RELEASE, when deb==0000:
  - idx+1 == len: go to DONE with a pass;
  - otherwise: idx increments and state returns to WAIT_PRESS.
REQ-027 Buttons added while in WAIT_RELEASE SHALL be ignored.
REQ-028 DONE SHALL last exactly one cycle, asserting pass or fail (never both), then return to IDLE.
REQ-029 Pass/fail latency: the pulse follows, by exactly one cycle, the clock edge at which the deciding deb condition was sampled.

Reset
REQ-030 On rst=1 at a clock edge:
  - state=IDLE; idx, len, debounce counter and timeout counter = 0;
  - deb and synchronizer = 0000;
  - busy, press_valid, pass, fail = 0; press_color = 00; fail_code = 00.
REQ-031 rst asserted mid-round SHALL abort without a pass or fail pulse.
REQ-032 rst SHALL take priority over start.

Configuration
REQ-033 Macro IV_PRESS_TIMEOUT_EN defined: a timeout counter runs in WAIT_PRESS only and clears on entering WAIT_PRESS.
  - On reaching TIMEOUT_CYCLES-1 with no press, the block goes to DONE with fail_code=11.
  - A press and a timeout in the same cycle resolve as the press.
REQ-034 Macro IV_PRESS_TIMEOUT_EN undefined: no timeout counter is built, WAIT_PRESS waits indefinitely, and fail_code 11 is never produced.

Verification
Bench parameters: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100.
REQ-035 Sequence {2,0,3}, len=3, with presses 0100, 0001, 1000, each released: three press_valid pulses (colors 2, 0, 3), then pass=1 for one cycle, fail_code=00, busy=0.
REQ-036 Sequence {1,1}, second press 0100: press_valid once, then fail=1 with fail_code=01.
REQ-037 First press 0011: fail=1 with fail_code=10; no press_valid.
REQ-038 Button 0001 glitching for 3 cycles: no press is detected. Button held for 6 cycles: press_valid occurs 2 (sync) + 4 (debounce) + 1 cycles after the btn edge.
REQ-039 With IV_PRESS_TIMEOUT_EN, no press for 100 cycles: fail with fail_code=11. Without the macro: busy stays 1 after 1000 cycles.
REQ-040 start with len=0 gives pass on the next cycle. rst mid-WAIT_RELEASE gives busy=0 and no pass or fail. start while busy leaves idx unchanged.
